// File: rtl/flash_lut_reader_if.sv
// rtl/flash_lut_reader_if.sv - lookup-table request/response bundle between exposure FSM and flash reader
interface flash_lut_reader_if;
    logic [23:0] fd_address;
    logic        fd_valid;
    logic [7:0]  fd;
    logic        fd_ready;
    logic        busy;

    modport master (output fd_address, fd_valid, input fd, fd_ready, busy);
    modport slave  (input fd_address, fd_valid, output fd, fd_ready, busy);
endinterface

// File: rtl/flash_lut_reader.sv
// rtl/flash_lut_reader.sv - single-byte SPI NOR READ controller serving LUT requests
module flash_lut_reader #(
    parameter int          CLK_DIV  = 4,
    parameter logic [7:0]  CMD_READ = 8'h03
) (
    input  logic               clk,
    input  logic               rstn,
    flash_lut_reader_if.slave  req,
    output logic               spi_cs_n,
    output logic               spi_sck,
    output logic               spi_mosi,
    input  logic               spi_miso
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETUP   = 3'd1;
    localparam logic [2:0] S_SHIFT   = 3'd2;
    localparam logic [2:0] S_DONE    = 3'd3;
    localparam logic [2:0] S_RECOVER = 3'd4;
    localparam int         DW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [2:0]    state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [5:0]    bit_q, bit_d;
    logic [31:0]   sr_q, sr_d;
    logic [7:0]    rx_q, rx_d, fd_q, fd_d;
    logic          rdy_q, rdy_d, busy_q, busy_d, rearm_q, rearm_d;
    logic          cs_n_q, cs_n_d, sck_q, sck_d, mosi_q, mosi_d;
    logic          phase_end;

    assign phase_end = (div_q == DIV_LAST);

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        sr_d    = sr_q;
        rx_d    = rx_q;
        fd_d    = fd_q;
        rdy_d   = 1'b0;
        busy_d  = busy_q;
        rearm_d = rearm_q;
        cs_n_d  = cs_n_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        case (state_q)
            S_IDLE: begin
                if (req.fd_valid && rearm_q) begin
                    sr_d    = {CMD_READ, req.fd_address};
                    cs_n_d  = 1'b0;
                    mosi_d  = CMD_READ[7];
                    busy_d  = 1'b1;
                    rearm_d = 1'b0;
                    div_d   = '0;
                    state_d = S_SETUP;
                end else if (!req.fd_valid) begin
                    rearm_d = 1'b1;
                end
            end
            S_SETUP: begin
                if (phase_end) begin
                    div_d   = '0;
                    sck_d   = 1'b1;
                    bit_d   = 6'd0;
                    state_d = S_SHIFT;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_SHIFT: begin
                if (!phase_end) begin
                    div_d = div_q + 1'b1;
                end else begin
                    div_d = '0;
                    if (sck_q) begin
                        // Falling edge: capture the read byte, launch the next command/address bit.
                        sck_d  = 1'b0;
                        sr_d   = {sr_q[30:0], 1'b0};
                        mosi_d = (bit_q < 6'd31) ? sr_q[30] : 1'b0;
                        if (bit_q >= 6'd32) rx_d = {rx_q[6:0], spi_miso};
                        if (bit_q == 6'd39) cs_n_d = 1'b1;
                    end else if (bit_q == 6'd39) begin
                        fd_d    = rx_q;
                        rdy_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        sck_d = 1'b1;
                        bit_d = bit_q + 6'd1;
                    end
                end
            end
            S_DONE: begin
                div_d   = '0;
                state_d = S_RECOVER;
            end
            S_RECOVER: begin
                if (!req.fd_valid) rearm_d = 1'b1;
                if (phase_end) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= 6'd0;
            sr_q    <= 32'h0;
            rx_q    <= 8'h00;
            fd_q    <= 8'h00;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
            rearm_q <= 1'b1;
            cs_n_q  <= 1'b1;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sr_q    <= sr_d;
            rx_q    <= rx_d;
            fd_q    <= fd_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
            rearm_q <= rearm_d;
            cs_n_q  <= cs_n_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
        end
    end

    assign req.fd       = fd_q;
    assign req.fd_ready = rdy_q;
    assign req.busy     = busy_q;
    assign spi_cs_n     = cs_n_q;
    assign spi_sck      = sck_q;
    assign spi_mosi     = mosi_q;
endmodule
